// File: rtl/sync_gate_pkg.sv
// sync_gate_pkg: one-hot state encoding shared by the sequencer and downstream decode logic
package sync_gate_pkg;
  localparam int NSTATES = 5;
  localparam int S_IDLE  = 0;
  localparam int S_SYNC  = 1;
  localparam int S_GATE  = 2;
  localparam int S_DRAIN = 3;
  localparam int S_DONE  = 4;
  typedef logic [NSTATES-1:0] state_t;
  localparam state_t ST_IDLE  = state_t'(1 << S_IDLE);
  localparam state_t ST_SYNC  = state_t'(1 << S_SYNC);
  localparam state_t ST_GATE  = state_t'(1 << S_GATE);
  localparam state_t ST_DRAIN = state_t'(1 << S_DRAIN);
  localparam state_t ST_DONE  = state_t'(1 << S_DONE);
endpackage

// File: rtl/sgs_down_counter.sv
// sgs_down_counter: loadable down counter that stops at zero (in: load, load_val, dec_en; out: cnt, zero)
module sgs_down_counter #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec_en,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);
  assign zero = cnt == '0;
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec_en && !zero) cnt <= cnt - 1'b1;
endmodule

// File: rtl/sync_gate_sequencer.sv
// sync_gate_sequencer: Sync/Gate/Done handshake sequencer (in: start, abort, sync_ack, hold, drain_empty; out: Sync, Gate, Done, busy, err, aborted, prev_state)
module sync_gate_sequencer
  import sync_gate_pkg::*;
#(
  parameter int SYNC_TIMEOUT = 16,
  parameter int GATE_CYCLES  = 8,
  parameter int CNT_W        = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       sync_ack,
  input  logic       hold,
  input  logic       drain_empty,
  output logic       Sync,
  output logic       Gate,
  output logic       Done,
  output logic       busy,
  output logic       err,
  output logic       aborted,
  output logic [4:0] prev_state
);
  state_t state, nxt;
  logic load, dec, zero, err_n, abt_n;
  logic [CNT_W-1:0] load_val, cnt;
  logic unused_cnt;
  assign unused_cnt = ^cnt;
  sgs_down_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .dec_en(dec), .cnt(cnt), .zero(zero)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state   <= ST_IDLE;
      err     <= 1'b0;
      aborted <= 1'b0;
    end else begin
      state   <= nxt;
      err     <= err_n;
      aborted <= abt_n;
    end
  always_comb begin
    nxt      = ST_IDLE;
    load     = 1'b0;
    load_val = '0;
    dec      = 1'b0;
    err_n    = 1'b0;
    abt_n    = 1'b0;
    if (!$onehot(state)) nxt = ST_IDLE;
    else if (abort && !state[S_IDLE]) abt_n = 1'b1;
    else if (state[S_IDLE]) begin
      nxt      = start ? ST_SYNC : ST_IDLE;
      load     = start;
      load_val = CNT_W'(SYNC_TIMEOUT - 1);
    end else if (state[S_SYNC]) begin
      nxt      = sync_ack ? ST_GATE : zero ? ST_IDLE : ST_SYNC;
      load     = sync_ack;
      load_val = CNT_W'(GATE_CYCLES - 1);
      dec      = !sync_ack;
      err_n    = !sync_ack && zero;
    end else if (state[S_GATE]) begin
      nxt = (hold || !zero) ? ST_GATE : ST_DRAIN;
      dec = !hold;
    end else if (state[S_DRAIN]) nxt = drain_empty ? ST_DONE : ST_DRAIN;
  end
  always_comb begin
    Sync       = state[S_SYNC];
    Gate       = state[S_GATE];
    Done       = state[S_DONE];
    busy       = state != ST_IDLE;
    prev_state = state;
  end
endmodule

// File: tb/tb_sync_gate_sequencer.sv
// tb_sync_gate_sequencer: directed scenarios plus randomized run against a phase/elapsed-count reference model
module tb_sync_gate_sequencer;
  localparam int ST = 16;
  localparam int GC = 8;
  logic clk = 0, rst = 1, start = 0, abort = 0, sync_ack = 0, hold = 0, drain_empty = 0;
  logic Sync, Gate, Done, busy, err, aborted;
  logic [4:0] prev_state;
  int checks = 0, errors = 0;
  int m_ph = 0, m_sn = 0, m_gn = 0;
  bit m_err = 0, m_abt = 0;
  bit mon = 0;
  logic [4:0] last_ps = 5'b00001;

  always #5 clk = ~clk;

  sync_gate_sequencer #(.SYNC_TIMEOUT(ST), .GATE_CYCLES(GC), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .sync_ack(sync_ack), .hold(hold),
    .drain_empty(drain_empty), .Sync(Sync), .Gate(Gate), .Done(Done), .busy(busy), .err(err),
    .aborted(aborted), .prev_state(prev_state)
  );

  always @(negedge clk) if (mon) begin
    checks++;
    if (!$onehot(prev_state)) begin
      errors++;
      $display("FAIL onehot: prev_state=%b, required one-hot", prev_state);
    end
    if (Done) begin
      checks++;
      if (last_ps !== 5'b01000) begin
        errors++;
        $display("FAIL done_after_drain: previous prev_state=%b, required 01000", last_ps);
      end
    end
    last_ps = prev_state;
  end

  // Phase 0..4 = idle/sync/gate/drain/done; m_sn counts Sync cycles so far, m_gn counts non-stalled Gate cycles
  task automatic model_next();
    m_err = 0;
    m_abt = 0;
    if (rst) m_ph = 0;
    else if (m_ph == 0) begin
      if (start) begin m_ph = 1; m_sn = 1; end
    end else if (abort) begin
      m_ph = 0;
      m_abt = 1;
    end else case (m_ph)
      1: if (sync_ack) begin m_ph = 2; m_gn = 1; end
         else if (m_sn == ST) begin m_ph = 0; m_err = 1; end
         else m_sn++;
      2: if (!hold) begin if (m_gn == GC) m_ph = 3; else m_gn++; end
      3: if (drain_empty) m_ph = 4;
      default: m_ph = 0;
    endcase
  endtask

  task automatic tick();
    model_next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    start = 0; abort = 0; sync_ack = 0; hold = 0; drain_empty = 0; rst = 0;
  endtask

  task automatic to_drain();
    start = 1; tick(); start = 0;
    sync_ack = 1; tick(); sync_ack = 0;
    repeat (GC) tick();
  endtask

  task automatic test_reset();
    rst = 1; start = 1; tick(); tick();
    checks++;
    if ({Sync, Gate, Done, busy, err, aborted, prev_state} !== 11'b000000_00001) begin
      errors++;
      $display("FAIL reset: outs=%b, required 00000000001", {Sync, Gate, Done, busy, err, aborted, prev_state});
    end
    idle_in();
    mon = 1;
  endtask

  task automatic test_nominal();
    for (int c = 0; c <= 16; c++) begin
      logic [4:0] e;
      e = (c == 0 || c == 16) ? 5'b00001 : c <= 3 ? 5'b00010 : c <= 11 ? 5'b00100 : c <= 14 ? 5'b01000 : 5'b10000;
      checks++;
      if ({Sync, Gate, Done, busy, err, aborted, prev_state} !== {e[1], e[2], e[4], !e[0], 2'b00, e}) begin
        errors++;
        $display("FAIL nominal c%0d: outs=%b, required %b", c, {Sync, Gate, Done, busy, err, aborted, prev_state},
                 {e[1], e[2], e[4], !e[0], 2'b00, e});
      end
      start = (c == 0); sync_ack = (c == 3); drain_empty = (c == 14);
      tick();
    end
    idle_in();
  endtask

  task automatic test_timeout();
    int ns = 0, ne = 0, g = 0;
    start = 1; tick(); start = 0;
    for (int i = 0; i < 24; i++) begin
      if (Sync) ns++;
      if (Gate) g++;
      if (err) begin
        ne++;
        checks++;
        if (prev_state !== 5'b00001) begin
          errors++;
          $display("FAIL timeout_err_idle: prev_state=%b, required 00001", prev_state);
        end
      end
      tick();
    end
    checks++;
    if (ns != ST || ne != 1 || g != 0) begin
      errors++;
      $display("FAIL timeout: sync=%0d err=%0d gate=%0d, required %0d 1 0", ns, ne, g, ST);
    end
  endtask

  task automatic test_ack_zero();
    int n = 0, ne = 0, gs = 0, dn = 0;
    start = 1; tick(); start = 0;
    drain_empty = 1;
    for (int i = 0; i < 32; i++) begin
      if (Sync) n++;
      if (err) ne++;
      if (Gate) gs++;
      if (Done) dn++;
      sync_ack = Sync && n == ST;
      tick();
    end
    idle_in();
    checks++;
    if (n != ST || ne != 0 || gs != GC || dn != 1) begin
      errors++;
      $display("FAIL ack_zero: sync=%0d err=%0d gate=%0d done=%0d, required %0d 0 %0d 1", n, ne, gs, dn, ST, GC);
    end
  endtask

  task automatic test_hold();
    int k = 0, hc = 0, gh = 0, dn = 0;
    start = 1; tick(); start = 0;
    sync_ack = 1; tick(); sync_ack = 0;
    drain_empty = 1;
    for (int i = 0; i < 20; i++) begin
      hold = 0;
      if (Done) dn++;
      if (Gate) begin
        gh++;
        checks++;
        if (dut.u_cnt.cnt !== 5'(GC - 1 - k)) begin
          errors++;
          $display("FAIL hold_cnt k%0d h%0d: cnt=%0d, required %0d", k, hc, dut.u_cnt.cnt, GC - 1 - k);
        end
        hold = (k == 3 && hc < 3);
        if (hold) hc++; else k++;
      end
      tick();
    end
    idle_in();
    checks++;
    if (gh != GC + 3 || dn != 1) begin
      errors++;
      $display("FAIL hold: gate=%0d done=%0d, required %0d 1", gh, dn, GC + 3);
    end
  endtask

  task automatic test_abort();
    start = 1; tick(); start = 0;
    sync_ack = 1; tick(); sync_ack = 0;
    tick();
    abort = 1; tick(); abort = 0;
    checks++;
    if (prev_state !== 5'b00001 || aborted !== 1 || Done !== 0 || Gate !== 0) begin
      errors++;
      $display("FAIL abort_gate: ps=%b aborted=%b done=%b gate=%b, required 00001 1 0 0", prev_state, aborted, Done, Gate);
    end
    tick();
    checks++;
    if (aborted !== 0) begin
      errors++;
      $display("FAIL abort_pulse: aborted=%b, required 0", aborted);
    end
    to_drain();
    checks++;
    if (prev_state !== 5'b01000) begin
      errors++;
      $display("FAIL abort_reach_drain: ps=%b, required 01000", prev_state);
    end
    abort = 1; drain_empty = 1; tick(); idle_in();
    checks++;
    if (prev_state !== 5'b00001 || aborted !== 1 || Done !== 0) begin
      errors++;
      $display("FAIL abort_drain: ps=%b aborted=%b done=%b, required 00001 1 0", prev_state, aborted, Done);
    end
    tick();
    checks++;
    if (Done !== 0 || busy !== 0) begin
      errors++;
      $display("FAIL abort_drain_after: done=%b busy=%b, required 0 0", Done, busy);
    end
    start = 1; tick(); start = 0;
    abort = 1; sync_ack = 1; tick(); idle_in();
    checks++;
    if (prev_state !== 5'b00001 || aborted !== 1 || Gate !== 0) begin
      errors++;
      $display("FAIL abort_sync: ps=%b aborted=%b gate=%b, required 00001 1 0", prev_state, aborted, Gate);
    end
    tick();
    abort = 1; tick();
    checks++;
    if (prev_state !== 5'b00001 || aborted !== 0 || busy !== 0) begin
      errors++;
      $display("FAIL abort_idle: ps=%b aborted=%b busy=%b, required 00001 0 0", prev_state, aborted, busy);
    end
    start = 1; tick(); idle_in();
    checks++;
    if (Sync !== 1 || aborted !== 0) begin
      errors++;
      $display("FAIL abort_idle_start: sync=%b aborted=%b, required 1 0", Sync, aborted);
    end
    abort = 1; tick(); idle_in(); tick();
  endtask

  task automatic test_reset_mid();
    to_drain();
    rst = 1; drain_empty = 1; tick(); idle_in();
    checks++;
    if ({Sync, Gate, Done, busy, err, aborted, prev_state} !== 11'b000000_00001) begin
      errors++;
      $display("FAIL reset_mid: outs=%b, required 00000000001", {Sync, Gate, Done, busy, err, aborted, prev_state});
    end
  endtask

  task automatic test_back_to_back();
    start = 1; sync_ack = 1; drain_empty = 1;
    for (int s = 0; s < 3; s++) begin
      int w = 0;
      while (!Done && w < 20) begin tick(); w++; end
      checks++;
      if (!Done) begin
        errors++;
        $display("FAIL b2b_done%0d: no Done within 20 cycles, required a Done pulse", s);
      end
      tick();
      checks++;
      if (prev_state !== 5'b00001) begin
        errors++;
        $display("FAIL b2b_idle%0d: ps=%b, required 00001", s, prev_state);
      end
      tick();
      checks++;
      if (Sync !== 1) begin
        errors++;
        $display("FAIL b2b_sync%0d: sync=%b, required 1", s, Sync);
      end
    end
    idle_in();
    abort = 1; tick(); idle_in(); tick();
  endtask

  task automatic test_random();
    rst = 1; tick(); rst = 0;
    for (int i = 0; i < 3000; i++) begin
      logic [10:0] e;
      rst = $urandom_range(99) == 0;
      start = $urandom_range(2) == 0;
      abort = $urandom_range(19) == 0;
      sync_ack = $urandom_range(5) == 0;
      hold = $urandom_range(2) == 0;
      drain_empty = $urandom_range(2) == 0;
      tick();
      e = {m_ph == 1, m_ph == 2, m_ph == 4, m_ph != 0, m_err, m_abt, 5'(1 << m_ph)};
      checks++;
      if ({Sync, Gate, Done, busy, err, aborted, prev_state} !== e) begin
        errors++;
        $display("FAIL random i%0d: outs=%b, required %b", i, {Sync, Gate, Done, busy, err, aborted, prev_state}, e);
      end
    end
    idle_in();
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_timeout();
    test_ack_zero();
    test_hold();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
